// File: rtl/dcache_ctrl.sv
// dcache_ctrl: direct-mapped write-back/write-allocate data cache; hits are combinational,
// misses stall the pipeline while the FSM writes back a dirty victim and refills the line.
module dcache_ctrl #(
    parameter int INDEX_W = 5,
    parameter int LINE_W  = 256
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              cpu_req_i,
    input  logic              cpu_we_i,
    input  logic [31:0]       cpu_addr_i,
    input  logic [31:0]       cpu_wdata_i,
    output logic [31:0]       cpu_rdata_o,
    output logic              cpu_stall_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [31:0]       mem_addr_o,
    output logic [LINE_W-1:0] mem_wdata_o,
    input  logic [LINE_W-1:0] mem_rdata_i,
    input  logic              mem_ack_i
);
    localparam int TAG_W = 32 - INDEX_W - 5;
    localparam int LINES = 1 << INDEX_W;

    typedef enum logic [1:0] {IDLE, WRITEBACK, ALLOCATE, FILL} state_t;

    state_t            r_state;
    logic [LINES-1:0]  r_valid;
    logic [LINES-1:0]  r_dirty;
    logic [TAG_W-1:0]  r_tag  [LINES];
    logic [LINE_W-1:0] r_data [LINES];

    logic [TAG_W-1:0]   w_tag;
    logic [INDEX_W-1:0] w_idx;
    logic [2:0]         w_word;
    logic               w_hit;
    logic               w_store_hit;
    logic               w_fill;
    logic               w_unused;

    assign w_tag       = cpu_addr_i[31:32-TAG_W];
    assign w_idx       = cpu_addr_i[INDEX_W+4:5];
    assign w_word      = cpu_addr_i[4:2];
    assign w_unused    = ^cpu_addr_i[1:0];
    assign w_hit       = r_valid[w_idx] & (r_tag[w_idx] == w_tag);
    assign w_store_hit = cpu_req_i & cpu_we_i & w_hit & (r_state == IDLE);
    assign w_fill      = (r_state == ALLOCATE) & mem_ack_i;
    assign cpu_stall_o = cpu_req_i & ((r_state != IDLE) | !w_hit);
    assign cpu_rdata_o = w_hit ? r_data[w_idx][{w_word, 5'b0} +: 32] : 32'd0;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state     <= IDLE;
            r_valid     <= '0;
            r_dirty     <= '0;
            mem_req_o   <= 1'b0;
            mem_we_o    <= 1'b0;
            mem_addr_o  <= '0;
            mem_wdata_o <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (cpu_req_i && !w_hit) begin
                        mem_req_o <= 1'b1;
                        if (r_valid[w_idx] && r_dirty[w_idx]) begin
                            r_state     <= WRITEBACK;
                            mem_we_o    <= 1'b1;
                            mem_addr_o  <= {r_tag[w_idx], w_idx, 5'b0};
                            mem_wdata_o <= r_data[w_idx];
                        end else begin
                            r_state    <= ALLOCATE;
                            mem_we_o   <= 1'b0;
                            mem_addr_o <= {w_tag, w_idx, 5'b0};
                        end
                    end else if (w_store_hit) begin
                        r_dirty[w_idx] <= 1'b1;
                    end
                end
                WRITEBACK: begin
                    if (mem_ack_i) begin
                        r_state    <= ALLOCATE;
                        mem_we_o   <= 1'b0;
                        mem_addr_o <= {w_tag, w_idx, 5'b0};
                    end
                end
                ALLOCATE: begin
                    if (mem_ack_i) begin
                        r_state        <= FILL;
                        mem_req_o      <= 1'b0;
                        r_valid[w_idx] <= 1'b1;
                        r_dirty[w_idx] <= 1'b0;
                    end
                end
                FILL: r_state <= IDLE;
            endcase
        end
    end

    // Tags and data are not reset; valid bits alone qualify them.
    always_ff @(posedge clk_i) begin
        if (w_fill) begin
            r_data[w_idx] <= mem_rdata_i;
            r_tag[w_idx]  <= w_tag;
        end else if (w_store_hit) begin
            r_data[w_idx][{w_word, 5'b0} +: 32] <= cpu_wdata_i;
        end
    end
endmodule

// File: tb/tb_dcache_ctrl.sv
// tb_dcache_ctrl: directed bench for dcache_ctrl with a cycle-counting memory responder
// and a table of back-to-back hit vectors.
module tb_dcache_ctrl;
    logic         clk_i = 1'b0;
    logic         rst_i = 1'b0;
    logic         cpu_req_i = 1'b0;
    logic         cpu_we_i = 1'b0;
    logic [31:0]  cpu_addr_i = '0;
    logic [31:0]  cpu_wdata_i = '0;
    logic [31:0]  cpu_rdata_o;
    logic         cpu_stall_o;
    logic         mem_req_o;
    logic         mem_we_o;
    logic [31:0]  mem_addr_o;
    logic [255:0] mem_wdata_o;
    logic [255:0] mem_rdata_i = '0;
    logic         mem_ack_i = 1'b0;

    int errors = 0;
    int checks = 0;
    logic         saw_wb;
    logic [31:0]  wb_addr, al_addr;
    logic [255:0] wb_data;

    dcache_ctrl dut (
        .clk_i(clk_i), .rst_i(rst_i), .cpu_req_i(cpu_req_i), .cpu_we_i(cpu_we_i),
        .cpu_addr_i(cpu_addr_i), .cpu_wdata_i(cpu_wdata_i), .cpu_rdata_o(cpu_rdata_o),
        .cpu_stall_o(cpu_stall_o), .mem_req_o(mem_req_o), .mem_we_o(mem_we_o),
        .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i),
        .mem_ack_i(mem_ack_i)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic        req;
        logic        we;
        logic        ack;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        stall;
        logic [31:0] rdata;
        logic        mreq;
    } vec_t;

    vec_t tv [10];

    task automatic chk(input string n, input logic [255:0] a, input logic [255:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %h want %h", n, a, e);
        end
    endtask

    function automatic logic [255:0] mk(input logic [31:0] b);
        logic [255:0] l;
        for (int i = 0; i < 8; i++) l[i*32 +: 32] = b + 32'(i);
        return l;
    endfunction

    task automatic drive(input logic req, input logic we, input logic [31:0] addr, input logic [31:0] wd);
        @(posedge clk_i);
        #1;
        cpu_req_i = req;
        cpu_we_i = we;
        cpu_addr_i = addr;
        cpu_wdata_i = wd;
    endtask

    // Acts as memory: acks the wbk-th write-back cycle and the alk-th fetch cycle,
    // counting every stalled cycle until the stall drops.
    task automatic serve(input int wbk, input int alk, input logic [255:0] line, output int stalls);
        int nwb = 0;
        int nal = 0;
        stalls = 0;
        saw_wb = 1'b0;
        for (int c = 0; c < 40; c++) begin
            #3;
            if (!cpu_stall_o) return;
            stalls++;
            if (mem_req_o && mem_we_o) begin
                nwb++;
                saw_wb = 1'b1;
                wb_addr = mem_addr_o;
                wb_data = mem_wdata_o;
                if (nwb == wbk) mem_ack_i = 1'b1;
            end else if (mem_req_o) begin
                nal++;
                al_addr = mem_addr_o;
                if (nal == alk) begin
                    mem_ack_i = 1'b1;
                    mem_rdata_i = line;
                end
            end
            @(posedge clk_i);
            #1;
            mem_ack_i = 1'b0;
        end
        checks++;
        errors++;
        $display("FAIL serve_timeout: stall still high after %0d cycles, want it to drop", stalls);
    endtask

    initial begin
        logic [255:0] l1, l1wb;
        int st;
        l1 = '0;
        l1[95:64] = 32'hDEADBEEF;
        l1wb = '0;
        l1wb[95:64] = 32'h12345678;

        // Reset state
        #3;
        chk("rst_stall", cpu_stall_o, 0);
        chk("rst_rdata", cpu_rdata_o, 0);
        chk("rst_mreq", mem_req_o, 0);
        chk("rst_mwe", mem_we_o, 0);
        chk("rst_maddr", mem_addr_o, 0);
        chk("rst_mwdata", mem_wdata_o, 0);
        @(posedge clk_i);
        #1 rst_i = 1'b1;

        // Cold load miss, ack in 3rd ALLOCATE cycle
        drive(1, 0, 32'h40, 0);
        serve(0, 3, l1, st);
        chk("t1_stalls", st, 5);
        chk("t1_no_wb", saw_wb, 0);
        chk("t1_al_addr", al_addr, 32'h40);
        chk("t1_rdata", cpu_rdata_o, 0);

        // Store hit then loads
        drive(1, 1, 32'h48, 32'h12345678);
        #3 chk("t2_st_stall", cpu_stall_o, 0);
        drive(1, 0, 32'h48, 0);
        #3 chk("t2_ld48", cpu_rdata_o, 32'h12345678);
        chk("t2_ld48_stall", cpu_stall_o, 0);
        drive(1, 0, 32'h44, 0);
        #3 chk("t2_ld44", cpu_rdata_o, 0);

        // Dirty conflict miss: write-back then allocate
        drive(1, 0, 32'h448, 0);
        serve(2, 1, mk(32'hA000_0000), st);
        chk("t3_stalls", st, 5);
        chk("t3_wb_seen", saw_wb, 1);
        chk("t3_wb_addr", wb_addr, 32'h40);
        chk("t3_wb_data", wb_data, l1wb);
        chk("t3_al_addr", al_addr, 32'h440);
        chk("t3_rdata", cpu_rdata_o, 32'hA000_0002);

        // Populate lines 4, 6, 8
        drive(1, 0, 32'h80, 0);
        serve(0, 1, mk(32'hB400_0000), st);
        chk("fill4_stalls", st, 3);
        drive(1, 0, 32'hC0, 0);
        serve(0, 1, mk(32'hB600_0000), st);
        chk("fill6_stalls", st, 3);
        drive(1, 0, 32'h100, 0);
        serve(0, 1, mk(32'hB800_0000), st);
        chk("fill8_stalls", st, 3);

        // Back-to-back hits, store hit, spurious acks in IDLE
        tv[0] = {1'b1, 1'b0, 1'b0, 32'h448, 32'h0,        1'b0, 32'hA000_0002, 1'b0};
        tv[1] = {1'b1, 1'b0, 1'b0, 32'h084, 32'h0,        1'b0, 32'hB400_0001, 1'b0};
        tv[2] = {1'b1, 1'b0, 1'b0, 32'h0C8, 32'h0,        1'b0, 32'hB600_0002, 1'b0};
        tv[3] = {1'b1, 1'b0, 1'b0, 32'h11C, 32'h0,        1'b0, 32'hB800_0007, 1'b0};
        tv[4] = {1'b1, 1'b0, 1'b0, 32'h440, 32'h0,        1'b0, 32'hA000_0000, 1'b0};
        tv[5] = {1'b1, 1'b1, 1'b0, 32'h0CC, 32'h55AA55AA, 1'b0, 32'hB600_0003, 1'b0};
        tv[6] = {1'b1, 1'b0, 1'b0, 32'h0CC, 32'h0,        1'b0, 32'h55AA55AA, 1'b0};
        tv[7] = {1'b0, 1'b0, 1'b1, 32'h084, 32'h0,        1'b0, 32'hB400_0001, 1'b0};
        tv[8] = {1'b1, 1'b0, 1'b1, 32'h084, 32'h0,        1'b0, 32'hB400_0001, 1'b0};
        tv[9] = {1'b1, 1'b0, 1'b0, 32'h084, 32'h0,        1'b0, 32'hB400_0001, 1'b0};
        for (int i = 0; i < 10; i++) begin
            drive(tv[i].req, tv[i].we, tv[i].addr, tv[i].wdata);
            mem_ack_i = tv[i].ack;
            mem_rdata_i = {8{32'hFFFF_FFFF}};
            #3;
            chk($sformatf("vec%0d_stall", i), cpu_stall_o, tv[i].stall);
            chk($sformatf("vec%0d_rdata", i), cpu_rdata_o, tv[i].rdata);
            chk($sformatf("vec%0d_mreq", i), mem_req_o, tv[i].mreq);
        end
        drive(0, 0, 0, 0);
        mem_ack_i = 1'b0;

        // Same index, old tag: clean (line 2 never stored since refill) full miss
        drive(1, 0, 32'h48, 0);
        serve(0, 1, l1wb, st);
        chk("t7_stalls", st, 3);
        chk("t7_no_wb", saw_wb, 0);
        chk("t7_rdata", cpu_rdata_o, 32'h12345678);

        // Reset in ALLOCATE before ack
        drive(1, 0, 32'h200, 0);
        #3 chk("t5_req_stall", cpu_stall_o, 1);
        @(posedge clk_i);
        #4;
        chk("t5_alloc_mreq", mem_req_o, 1);
        chk("t5_alloc_addr", mem_addr_o, 32'h200);
        rst_i = 1'b0;
        #1;
        chk("t5_rst_mreq", mem_req_o, 0);
        chk("t5_rst_stall", cpu_stall_o, 1);
        chk("t5_rst_maddr", mem_addr_o, 0);
        cpu_req_i = 1'b0;
        #1 chk("t5_rst_noreq", cpu_stall_o, 0);
        @(posedge clk_i);
        #1 rst_i = 1'b1;
        drive(1, 0, 32'h84, 0);
        #3 chk("t5_cold_again", cpu_stall_o, 1);
        serve(0, 1, mk(32'hB400_0000), st);
        chk("t5_refill_stalls", st, 3);
        chk("t5_refill_rdata", cpu_rdata_o, 32'hB400_0001);
        drive(1, 0, 32'h204, 0);
        serve(0, 1, mk(32'hC000_0000), st);
        chk("t5_retry_stalls", st, 3);
        chk("t5_retry_addr", al_addr, 32'h200);
        chk("t5_retry_rdata", cpu_rdata_o, 32'hC000_0001);

        drive(0, 0, 0, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
